// File: rtl/top.sv
// -----------------------------------------------------------------------------
// top -- SPI flash boot loader.
//
// After reset release the block wakes the flash (0xAB), waits a short gap with
// chip select released, then issues one READ (0x03, address 0) and streams
// BOOT_WORDS 32-bit words out of the flash in a single burst. Each assembled
// word is presented on boot_data/boot_index with a one-cycle boot_valid pulse.
// gpio_out_pad is raised with the last word and held until reset.
//
// Parameters:
//   BOOT_WORDS  number of 32-bit words fetched (1..65536)
//   GAP_CYCLES  core_clk cycles chip select stays high between commands (>= 1)
//
// Ports:
//   core_clk       in   system clock, rising edge
//   core_rst       in   asynchronous reset, active low
//   spiflash_cs_n  out  flash chip select, active low
//   spiflash_clk   out  flash serial clock, SPI mode 0, core_clk/2
//   spiflash_mosi  out  serial data to flash, MSB first
//   spiflash_miso  in   serial data from flash, MSB first
//   boot_data      out  last assembled word (little-endian byte packing)
//   boot_valid     out  one-cycle pulse: boot_data/boot_index updated
//   boot_index     out  word index of boot_data
//   gpio_out_pad   out  boot-done flag
// -----------------------------------------------------------------------------
module top #(
  parameter int unsigned BOOT_WORDS = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        core_clk,
  input  logic        core_rst,
  output logic        spiflash_cs_n,
  output logic        spiflash_clk,
  output logic        spiflash_mosi,
  input  logic        spiflash_miso,
  output logic [31:0] boot_data,
  output logic        boot_valid,
  output logic [15:0] boot_index,
  output logic        gpio_out_pad
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAKE = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0]  WAKE_CMD = 8'hAB;
  localparam logic [31:0] READ_CMD = 32'h0300_0000;

  // Inside WAKE/READ the cycle counter runs 0..2*bits: even = sclk low,
  // odd = sclk high, final even value = trailing cycle with sclk low and
  // cs_n still asserted.
  localparam int unsigned WAKE_CYC = 16;
  localparam int unsigned READ_CYC = 64 * (BOOT_WORDS + 1);
  localparam int unsigned CNT_MAX  = (READ_CYC > GAP_CYCLES) ? READ_CYC : GAP_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned WW       = CW - 6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [30:0]   data_sr_q, data_sr_d;
  logic [31:0]   boot_data_q, boot_data_d;
  logic          boot_valid_q, boot_valid_d;
  logic [15:0]   boot_index_q, boot_index_d;
  logic          gpio_q, gpio_d;

  logic          active_d;
  logic          sample_en;
  logic          word_end;
  logic [31:0]   word_w;
  logic [WW-1:0] word_num;

  // Next state / counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        state_d = S_WAKE;
        cnt_d   = '0;
      end
      S_WAKE: begin
        if (cnt_q == CW'(WAKE_CYC)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        if (cnt_q == CW'(READ_CYC)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // SPI pins are registered and derived from the next state/counter so they
  // line up exactly with the state register.
  always_comb begin
    active_d = (state_d == S_WAKE) || (state_d == S_READ);
    cs_n_d   = !active_d;
    sclk_d   = active_d && cnt_d[0];
    mosi_d   = 1'b0;
    if (state_d == S_WAKE && cnt_d < CW'(WAKE_CYC)) begin
      mosi_d = WAKE_CMD[~cnt_d[3:1]];
    end else if (state_d == S_READ && cnt_d[CW-1:6] == '0) begin
      mosi_d = READ_CMD[~cnt_d[5:1]];
    end
  end

  // Capture: miso sampled on the edge that raises sclk during the data phase
  // (bit index >= 32, trailing cycle excluded).
  always_comb begin
    word_num  = cnt_q[CW-1:6];
    sample_en = (state_q == S_READ) && !cnt_q[0] && (word_num != '0) &&
                (cnt_q != CW'(READ_CYC));
    word_end  = sample_en && (cnt_q[5:1] == 5'd31);
    word_w    = {data_sr_q, spiflash_miso};

    data_sr_d    = sample_en ? word_w[30:0] : data_sr_q;
    boot_valid_d = word_end;
    boot_data_d  = boot_data_q;
    boot_index_d = boot_index_q;
    gpio_d       = gpio_q;
    if (word_end) begin
      // First byte on the wire lands in [31:24] of the shift word; swap so it
      // ends up in boot_data[7:0].
      boot_data_d  = {word_w[7:0], word_w[15:8], word_w[23:16], word_w[31:24]};
      boot_index_d = 16'(word_num - WW'(1));
      if (word_num == WW'(BOOT_WORDS)) begin
        gpio_d = 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or negedge core_rst) begin
    if (!core_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      data_sr_q    <= '0;
      boot_data_q  <= '0;
      boot_valid_q <= 1'b0;
      boot_index_q <= '0;
      gpio_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      data_sr_q    <= data_sr_d;
      boot_data_q  <= boot_data_d;
      boot_valid_q <= boot_valid_d;
      boot_index_q <= boot_index_d;
      gpio_q       <= gpio_d;
    end
  end

  assign spiflash_cs_n = cs_n_q;
  assign spiflash_clk  = sclk_q;
  assign spiflash_mosi = mosi_q;
  assign boot_data     = boot_data_q;
  assign boot_valid    = boot_valid_q;
  assign boot_index    = boot_index_q;
  assign gpio_out_pad  = gpio_q;

endmodule

// File: tb/tb_top.sv
// -----------------------------------------------------------------------------
// tb_top -- bench for the SPI flash boot loader.
// Instance A: BOOT_WORDS=16, GAP_CYCLES=4. Instance B: BOOT_WORDS=1,
// GAP_CYCLES=2. Both share clock and reset; each has a behavioural SPI flash
// that decodes the command it receives and returns bytes from its memory.
// -----------------------------------------------------------------------------
module tb_top;

  localparam int unsigned BW_A  = 16;
  localparam int unsigned GAP_A = 4;
  localparam int unsigned BW_B  = 1;
  localparam int unsigned GAP_B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cs_a, sclk_a, mosi_a, valid_a, gpio_a;
  logic        miso_a = 1'b0;
  logic [31:0] data_a;
  logic [15:0] idx_a;
  logic        cs_b, sclk_b, mosi_b, valid_b, gpio_b;
  logic        miso_b = 1'b0;
  logic [31:0] data_b;
  logic [15:0] idx_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]  mem_a [1024];
  logic [7:0]  mem_b [1024];
  logic [31:0] exp_a [BW_A];
  logic [31:0] exp_b;

  always #5 clk = ~clk;

  top #(.BOOT_WORDS(BW_A), .GAP_CYCLES(GAP_A)) u_dut_a (
    .core_clk(clk), .core_rst(rst),
    .spiflash_cs_n(cs_a), .spiflash_clk(sclk_a), .spiflash_mosi(mosi_a),
    .spiflash_miso(miso_a),
    .boot_data(data_a), .boot_valid(valid_a), .boot_index(idx_a),
    .gpio_out_pad(gpio_a)
  );

  top #(.BOOT_WORDS(BW_B), .GAP_CYCLES(GAP_B)) u_dut_b (
    .core_clk(clk), .core_rst(rst),
    .spiflash_cs_n(cs_b), .spiflash_clk(sclk_b), .spiflash_mosi(mosi_b),
    .spiflash_miso(miso_b),
    .boot_data(data_b), .boot_valid(valid_b), .boot_index(idx_b),
    .gpio_out_pad(gpio_b)
  );

  // Behavioural flash: counts sclk rising edges per cs_n session, captures the
  // first 32 mosi bits as command+address, and for a 0x03 read shifts memory
  // bytes out MSB first, changing miso on sclk falling edges.
  function automatic logic flash_bit(input logic [31:0] cmd, input int unsigned nb,
                                     input bit which);
    int unsigned d, a;
    if (nb < 32 || cmd[31:24] != 8'h03) return 1'b0;
    d = nb - 32;
    a = int'(cmd[23:0]) + d / 8;
    if (a >= 1024) return 1'b0;
    return which ? mem_b[a][7 - (d % 8)] : mem_a[a][7 - (d % 8)];
  endfunction

  int unsigned nb_a = 0, nb_b = 0;
  logic [31:0] cmd_a = '0, cmd_b = '0;

  always @(negedge cs_a or posedge sclk_a) begin
    if (!sclk_a) begin
      nb_a  <= 0;
      cmd_a <= '0;
    end else if (!cs_a) begin
      if (nb_a < 32) cmd_a <= {cmd_a[30:0], mosi_a};
      nb_a <= nb_a + 1;
    end
  end
  always @(negedge sclk_a) if (!cs_a) miso_a <= flash_bit(cmd_a, nb_a, 1'b0);

  always @(negedge cs_b or posedge sclk_b) begin
    if (!sclk_b) begin
      nb_b  <= 0;
      cmd_b <= '0;
    end else if (!cs_b) begin
      if (nb_b < 32) cmd_b <= {cmd_b[30:0], mosi_b};
      nb_b <= nb_b + 1;
    end
  end
  always @(negedge sclk_b) if (!cs_b) miso_b <= flash_bit(cmd_b, nb_b, 1'b1);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: bytes 00,01,02..  mode 1: random  mode 2: all FF
  task automatic load_mem(input int mode);
    for (int unsigned i = 0; i < 1024; i++) begin
      case (mode)
        0:       mem_a[i] = 8'(i);
        1:       mem_a[i] = 8'($urandom);
        default: mem_a[i] = 8'hFF;
      endcase
      mem_b[i] = 8'($urandom);
    end
    for (int unsigned w = 0; w < BW_A; w++)
      exp_a[w] = {mem_a[4*w+3], mem_a[4*w+2], mem_a[4*w+1], mem_a[4*w]};
    exp_b = {mem_b[3], mem_b[2], mem_b[1], mem_b[0]};
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cs_n"},  64'(cs_a),   64'd1);
    chk({tag, ".sclk"},  64'(sclk_a), 64'd0);
    chk({tag, ".mosi"},  64'(mosi_a), 64'd0);
    chk({tag, ".data"},  64'(data_a), 64'd0);
    chk({tag, ".valid"}, 64'(valid_a), 64'd0);
    chk({tag, ".index"}, 64'(idx_a),  64'd0);
    chk({tag, ".gpio"},  64'(gpio_a), 64'd0);
    chk({tag, ".b_cs_n"}, 64'(cs_b),  64'd1);
    chk({tag, ".b_data"}, 64'(data_b), 64'd0);
    chk({tag, ".b_gpio"}, 64'(gpio_b), 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Follows one complete boot from reset release (cycle k = edges since
  // release), then watches 1000 further cycles for stray flash traffic.
  task automatic boot_check(input string tag);
    int unsigned fall_c[$];
    int unsigned rise_c[$];
    logic [31:0] bits [2];
    int unsigned edges [2];
    int          sess = -1;
    logic        pcs = 1'b1, psclk = 1'b0;
    int unsigned nv = 0, nvb = 0;
    int unsigned idle_bad = 0, mosi_bad = 0, gpio_bad = 0, gpiob_bad = 0, quiet_bad = 0;
    int unsigned rd_fall;
    bits[0] = '0; bits[1] = '0; edges[0] = 0; edges[1] = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(posedge clk); #1;
      if (pcs && !cs_a) begin sess++; fall_c.push_back(k); end
      if (!pcs && cs_a) rise_c.push_back(k);
      if (cs_a && (sclk_a || mosi_a)) idle_bad++;
      if (!cs_a && sclk_a && !psclk && sess >= 0 && sess < 2) begin
        edges[sess]++;
        if (edges[sess] <= 32) bits[sess] = {bits[sess][30:0], mosi_a};
      end
      if (sess == 1 && !cs_a && edges[1] >= 32 && mosi_a) mosi_bad++;
      if (valid_a) begin
        rd_fall = (fall_c.size() > 1) ? fall_c[1] : 0;
        chk({tag, ".data"}, 64'(data_a), 64'((nv < BW_A) ? exp_a[nv] : 32'hDEAD_BEEF));
        chk({tag, ".index"}, 64'(idx_a), 64'(nv));
        // Word nv completes at wire bit 63+32*nv; valid is the cycle that bit's
        // sclk is high.
        chk({tag, ".valid_cycle"}, 64'(k), 64'(rd_fall + 2 * (32 + 32 * (nv + 1)) - 1));
        chk({tag, ".gpio_at_valid"}, 64'(gpio_a), 64'(nv == BW_A - 1));
        nv++;
      end else if (gpio_a !== (nv == BW_A)) begin
        gpio_bad++;
      end
      if (valid_b) begin
        chk({tag, ".b_data"}, 64'(data_b), 64'(exp_b));
        chk({tag, ".b_index"}, 64'(idx_b), 64'd0);
        chk({tag, ".b_gpio_at_valid"}, 64'(gpio_b), 64'd1);
        nvb++;
      end else if (gpio_b !== (nvb >= BW_B)) begin
        gpiob_bad++;
      end
      pcs = cs_a;
      psclk = sclk_a;
    end
    chk({tag, ".cs_falls"}, 64'(fall_c.size()), 64'd2);
    chk({tag, ".cs_rises"}, 64'(rise_c.size()), 64'd2);
    if (fall_c.size() == 2 && rise_c.size() == 2) begin
      chk({tag, ".wake_start"}, 64'(fall_c[0]), 64'd1);
      // 8 bits * 2 cycles plus one trailing cycle after the last sclk fall
      chk({tag, ".wake_len"}, 64'(rise_c[0] - fall_c[0]), 64'd17);
      chk({tag, ".gap_len"},  64'(fall_c[1] - rise_c[0]), 64'(GAP_A));
      chk({tag, ".read_len"}, 64'(rise_c[1] - fall_c[1]), 64'(2 * (32 + 32 * BW_A) + 1));
    end
    chk({tag, ".wake_edges"}, 64'(edges[0]), 64'd8);
    chk({tag, ".wake_cmd"},   64'(bits[0]),  64'h0000_00AB);
    chk({tag, ".read_edges"}, 64'(edges[1]), 64'(32 + 32 * BW_A));
    chk({tag, ".read_cmd"},   64'(bits[1]),  64'h0300_0000);
    chk({tag, ".pulses"},     64'(nv),       64'(BW_A));
    chk({tag, ".b_pulses"},   64'(nvb),      64'(BW_B));
    chk({tag, ".idle_pins"},  64'(idle_bad), 64'd0);
    chk({tag, ".data_mosi"},  64'(mosi_bad), 64'd0);
    chk({tag, ".gpio_track"}, 64'(gpio_bad), 64'd0);
    chk({tag, ".b_gpio_track"}, 64'(gpiob_bad), 64'd0);
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (!cs_a || sclk_a || valid_a || !gpio_a || !cs_b || valid_b || !gpio_b) quiet_bad++;
    end
    chk({tag, ".done_quiet"}, 64'(quiet_bad), 64'd0);
  endtask

  initial begin
    bit found;
    load_mem(0);
    #2 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_reset("reset");

    // Incrementing bytes 00..3F
    release_reset();
    chk("idle_cycle.cs_n", 64'(cs_a), 64'd1);
    boot_check("inc");

    // Random contents
    rst = 1'b0;
    load_mem(1);
    repeat (5) @(posedge clk);
    release_reset();
    boot_check("rand");

    // All 0xFF
    rst = 1'b0;
    load_mem(2);
    repeat (5) @(posedge clk);
    #1;
    check_reset("reset2");
    release_reset();
    boot_check("ff");

    // Abort during the 5th word, then a full restart
    rst = 1'b0;
    load_mem(1);
    repeat (5) @(posedge clk);
    release_reset();
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(posedge clk); #1;
      if (valid_a && idx_a == 16'd3) found = 1'b1;
    end
    chk("abort.reach_word4", 64'(found), 64'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("abort.mid_transfer_cs", 64'(cs_a), 64'd0);
    #1 rst = 1'b0;
    #1;
    check_reset("abort");
    repeat (10) @(posedge clk);
    load_mem(1);
    release_reset();
    boot_check("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter BOOT_WORDS, default 16: number of 32-bit words fetched from flash after reset (range 1..65536).
REQ-002 Parameter GAP_CYCLES, default 4: core_clk cycles spiflash_cs_n is held high between commands (minimum 1).
REQ-003 core_clk  input  1  system clock; all logic on its rising edge.
REQ-004 core_rst  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 spiflash_cs_n  output  1  flash chip select, active low.
REQ-006 spiflash_clk  output  1  flash serial clock, SPI mode 0, frequency core_clk/2.
REQ-007 spiflash_mosi  output  1  serial data to flash, MSB first.
REQ-008 spiflash_miso  input  1  serial data from flash, MSB first.
REQ-009 boot_data  output  32  most recently assembled flash word.
REQ-010 boot_valid  output  1  one-cycle pulse: boot_data/boot_index newly valid.
REQ-011 boot_index  output  16  word index of boot_data (0..BOOT_WORDS-1).
REQ-012 gpio_out_pad  output  1  boot-done flag; 1 once all words are fetched.

Function
REQ-013 States: IDLE, WAKE, GAP, READ, DONE; exactly one active at a time.
REQ-014 IDLE lasts exactly 1 cycle after reset release, then WAKE.
REQ-015 WAKE: cs_n=0; shift out 8 bits of 0xAB (release power-down), then GAP.
REQ-016 GAP: cs_n=1, sclk=0 for GAP_CYCLES cycles, then READ.
REQ-017 READ: cs_n=0; shift out 0x03 then 24-bit address 0x000000 (32 bits), then clock in 32*BOOT_WORDS bits in one continuous burst, then DONE.
REQ-018 Bit timing: each bit occupies 2 core_clk cycles; mosi is updated on the edge that drives sclk low (or on cs_n assertion for the first bit); sclk goes high on the next edge.
REQ-019 miso is sampled at the core_clk edge that drives sclk 0->1 (value present before that edge).
REQ-020 sclk is 0 whenever cs_n=1; cs_n falls with sclk=0 and rises one cycle after the final sclk falling edge.
REQ-021 mosi is 0 while cs_n=1 and during the data phase of READ.
REQ-022 Byte assembly: bytes MSB-first on the wire; word packed little-endian (first byte of each group of 4 -> boot_data[7:0], fourth -> [31:24]).
REQ-023 boot_valid pulses for exactly 1 cycle, the cycle after the 32nd bit of a word is sampled; boot_data and boot_index update in that same cycle and hold until the next pulse.
REQ-024 boot_index = 0 for the first word, incrementing by 1 per word; no wrap within a boot.
REQ-025 DONE: cs_n=1, sclk=0, gpio_out_pad=1; remains until reset; no further flash traffic.
REQ-026 gpio_out_pad rises in the same cycle as the last boot_valid pulse.

Reset
REQ-027 While core_rst=0: state IDLE, cs_n=1, sclk=0, mosi=0, boot_data=0, boot_valid=0, boot_index=0, gpio_out_pad=0, all counters cleared.
REQ-028 Reset asserted mid-transfer aborts immediately (cs_n=1 asynchronously); after release the full sequence restarts from IDLE with address 0.

Verification
REQ-029 Reset held 100 cycles, released -> cs_n falls 1 cycle later; mosi carries 10101011 over 8 sclk rising edges; cs_n then high exactly 4 cycles (GAP_CYCLES=4).
REQ-030 Flash model holding bytes 00..3F at addresses 0..63 -> mosi shows 0x03 000000; boot_valid pulses 16 times; boot_data[0]=0x03020100, boot_data[15]=0x3F3E3D3C; boot_index 0..15.
REQ-031 Cycle counting: READ burst spans 2*(32+32*16)=1088 core_clk cycles with cs_n low continuously; consecutive boot_valid pulses exactly 64 cycles apart.
REQ-032 Flash returning all 0xFF -> every boot_data=0xFFFFFFFF; gpio_out_pad=1 after last pulse and cs_n stays 1 for 1000 further cycles.
REQ-033 Reset asserted during the 5th word -> cs_n=1 and outputs cleared without waiting for a clock; after release the wake command repeats and boot_index restarts at 0.
REQ-034 BOOT_WORDS=1 -> exactly one boot_valid pulse, gpio_out_pad rising in the same cycle.
